// File: rtl/ht_cmd_traffic_gen.sv
// Hash-table command traffic generator: issues LFSR-driven INIT/SEARCH/INSERT/DELETE
// commands under valid/ready, capping commands still waiting for a result.
package ht_pkg;
   typedef enum logic [1:0] {
      OP_INIT   = 2'd0,
      OP_SEARCH = 2'd1,
      OP_INSERT = 2'd2,
      OP_DELETE = 2'd3
   } ht_opcode_t;
endpackage

module ht_cmd_traffic_gen
   import ht_pkg::*;
#(
   parameter int KEY_WIDTH       = 32,
   parameter int VALUE_WIDTH     = 16,
   parameter int BUCKET_WIDTH    = 8,
   parameter int CNT_WIDTH       = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 start_i,
   input  logic                                 abort_i,
   input  logic [1:0]                           mode_i,
   input  logic                                 init_first_i,
   input  logic                                 mixed_init_en_i,
   input  logic [CNT_WIDTH-1:0]                 cmd_cnt_i,
   input  logic [31:0]                          seed_i,
   input  logic [BUCKET_WIDTH-1:0]              bucket_base_i,
   input  logic [BUCKET_WIDTH-1:0]              bucket_mask_i,
   input  logic [KEY_WIDTH-BUCKET_WIDTH-1:0]    key_low_mask_i,
   output logic                                 cmd_valid_o,
   input  logic                                 cmd_ready_i,
   output ht_opcode_t                           cmd_opcode_o,
   output logic [KEY_WIDTH-1:0]                 cmd_key_o,
   output logic [VALUE_WIDTH-1:0]               cmd_value_o,
   input  logic                                 res_valid_i,
   output logic                                 res_ready_o,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic [CNT_WIDTH-1:0]                 cmds_sent_o,
   output logic [CNT_WIDTH-1:0]                 results_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

   localparam int LW  = KEY_WIDTH - BUCKET_WIDTH;
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int ROT = 16 % VALUE_WIDTH;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]              state_q;
   logic [1:0]              mode_q;
   logic [BUCKET_WIDTH-1:0] base_q;
   logic [BUCKET_WIDTH-1:0] bmask_q;
   logic [LW-1:0]           kmask_q;
   logic [CNT_WIDTH-1:0]    rem_q;
   logic [31:0]             lfsr_q;
   logic                    pend_q;
   logic                    abort_q;
   ht_opcode_t              op_q;
   logic [KEY_WIDTH-1:0]    key_q;
   logic [VALUE_WIDTH-1:0]  val_q;
   logic [CNT_WIDTH-1:0]    sent_q;
   logic [CNT_WIDTH-1:0]    res_q;
   logic [OW-1:0]           outst_q;

   logic        full;
   logic        hs;
   logic        res_acc;
   logic        active;
   logic        abort_eff;
   logic        stop_now;
   logic        last;
   logic [31:0] lfsr_nx;
   logic [31:0] seed_eff;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   function automatic logic [KEY_WIDTH-1:0] mk_key(
      input logic [31:0]             s,
      input logic [BUCKET_WIDTH-1:0] base,
      input logic [BUCKET_WIDTH-1:0] bmask,
      input logic [LW-1:0]           kmask
   );
      logic [LW-1:0]           low;
      logic [BUCKET_WIDTH-1:0] bkt;
      // low key field comes from lfsr[31:8], zero-extended or truncated
      for (int i = 0; i < LW; i++)
         low[i] = (i < 24) ? s[(8 + i) & 31] : 1'b0;
      bkt    = base | (s[BUCKET_WIDTH-1:0] & bmask);
      mk_key = {bkt, low & kmask};
   endfunction

   function automatic logic [VALUE_WIDTH-1:0] mk_val(input logic [31:0] s);
      for (int j = 0; j < VALUE_WIDTH; j++)
         mk_val[j] = s[(j + VALUE_WIDTH - ROT) % VALUE_WIDTH];
   endfunction

   function automatic ht_opcode_t mk_op(
      input logic [1:0] sel,
      input logic [1:0] mode,
      input logic       mix
   );
      if (mode == 2'd1) begin
         mk_op = OP_INSERT;
      end else begin
         case (sel)
            2'b00:   mk_op = OP_SEARCH;
            2'b01:   mk_op = OP_INSERT;
            2'b10:   mk_op = OP_DELETE;
            default: mk_op = (mode == 2'd2 && mix) ? OP_INIT : OP_SEARCH;
         endcase
      end
   endfunction

   always_comb begin
      full        = (outst_q == OW'(MAX_OUTSTANDING));
      cmd_valid_o = pend_q & ~(full & ~res_valid_i);
      hs          = cmd_valid_o & cmd_ready_i;
      res_acc     = res_valid_i & (outst_q != '0);
      active      = (state_q == S_INIT) || (state_q == S_RUN);
      abort_eff   = abort_i | abort_q;
      stop_now    = active & abort_eff & (~cmd_valid_o | hs);
      last        = (rem_q == CNT_WIDTH'(1));
      lfsr_nx     = lfsr_step(lfsr_q);
      seed_eff    = (seed_i == 32'h0) ? 32'h1 : seed_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         mode_q  <= 2'd0;
         base_q  <= '0;
         bmask_q <= '0;
         kmask_q <= '0;
         rem_q   <= '0;
         lfsr_q  <= 32'h1;
         pend_q  <= 1'b0;
         abort_q <= 1'b0;
         op_q    <= OP_INIT;
         key_q   <= '0;
         val_q   <= '0;
         sent_q  <= '0;
         res_q   <= '0;
         outst_q <= '0;
      end else begin
         if (hs && !res_acc)
            outst_q <= outst_q + 1'b1;
         else if (!hs && res_acc)
            outst_q <= outst_q - 1'b1;
         if (hs && !(&sent_q))
            sent_q <= sent_q + 1'b1;
         if (res_acc && !(&res_q))
            res_q <= res_q + 1'b1;

         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  mode_q  <= mode_i;
                  base_q  <= bucket_base_i;
                  bmask_q <= bucket_mask_i;
                  kmask_q <= key_low_mask_i;
                  rem_q   <= cmd_cnt_i;
                  lfsr_q  <= seed_eff;
                  abort_q <= 1'b0;
                  sent_q  <= '0;
                  res_q   <= '0;
                  if (init_first_i || mode_i == 2'd0) begin
                     state_q <= S_INIT;
                     pend_q  <= 1'b1;
                     op_q    <= OP_INIT;
                     key_q   <= '0;
                     val_q   <= '0;
                  end else if (cmd_cnt_i == '0) begin
                     state_q <= S_DRAIN;
                     pend_q  <= 1'b0;
                  end else begin
                     state_q <= S_RUN;
                     pend_q  <= 1'b1;
                     op_q    <= mk_op(seed_eff[31:30], mode_i, mixed_init_en_i);
                     key_q   <= mk_key(seed_eff, bucket_base_i,
                                       bucket_mask_i, key_low_mask_i);
                     val_q   <= mk_val(seed_eff);
                  end
               end
            end
            S_INIT: begin
               if (hs) begin
                  if (mode_q == 2'd0 || rem_q == '0 || abort_eff) begin
                     state_q <= S_DRAIN;
                     pend_q  <= 1'b0;
                  end else begin
                     // first run command uses the unadvanced seed
                     state_q <= S_RUN;
                     op_q    <= mk_op(lfsr_q[31:30], mode_q, mixed_init_en_i);
                     key_q   <= mk_key(lfsr_q, base_q, bmask_q, kmask_q);
                     val_q   <= mk_val(lfsr_q);
                  end
               end else if (stop_now) begin
                  state_q <= S_DRAIN;
                  pend_q  <= 1'b0;
               end else if (abort_i) begin
                  abort_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (hs) begin
                  lfsr_q <= lfsr_nx;
                  rem_q  <= rem_q - 1'b1;
                  if (last || abort_eff) begin
                     state_q <= S_DRAIN;
                     pend_q  <= 1'b0;
                  end else begin
                     op_q  <= mk_op(lfsr_nx[31:30], mode_q, mixed_init_en_i);
                     key_q <= mk_key(lfsr_nx, base_q, bmask_q, kmask_q);
                     val_q <= mk_val(lfsr_nx);
                  end
               end else if (stop_now) begin
                  state_q <= S_DRAIN;
                  pend_q  <= 1'b0;
               end else if (abort_i) begin
                  abort_q <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (outst_q == '0)
                  state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               pend_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_opcode_o  = op_q;
   assign cmd_key_o     = key_q;
   assign cmd_value_o   = val_q;
   assign res_ready_o   = 1'b1;
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign cmds_sent_o   = sent_q;
   assign results_o     = res_q;
   assign outstanding_o = outst_q;

endmodule

// File: tb/tb_ht_cmd_traffic_gen.sv
// Bench for ht_cmd_traffic_gen: table-driven runs, random runs and corner sequences
// checked against an expected-command queue and an outstanding/counter model.
module tb_ht_cmd_traffic_gen;
   import ht_pkg::*;

   localparam int MAXO = 8;

   typedef struct {
      ht_opcode_t  op;
      logic [31:0] key;
      logic [15:0] val;
   } cmd_t;

   typedef struct {
      logic [1:0]  mode;
      logic        init_first;
      logic        mix;
      int          cnt;
      logic [31:0] seed;
      logic [7:0]  base;
      logic [7:0]  bm;
      logic [23:0] km;
      int          rdy_pct;
      int          res_pct;
      int          exp_sent;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, abort, init_first, mix, cmd_ready, res_valid;
   logic [1:0]  mode;
   logic [15:0] cmd_cnt;
   logic [31:0] seed;
   logic [7:0]  base, bm;
   logic [23:0] km;
   logic        cmd_valid, res_ready, busy, done;
   ht_opcode_t  opcode;
   logic [31:0] key;
   logic [15:0] value;
   logic [15:0] cmds_sent, results;
   logic [3:0]  outstanding;

   int   total = 0;
   int   bad = 0;
   int   out_m, sent_m, res_m;
   logic held;
   cmd_t hv;
   cmd_t expq[$];

   ht_cmd_traffic_gen dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .mode_i(mode), .init_first_i(init_first), .mixed_init_en_i(mix),
      .cmd_cnt_i(cmd_cnt), .seed_i(seed), .bucket_base_i(base),
      .bucket_mask_i(bm), .key_low_mask_i(km),
      .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
      .cmd_opcode_o(opcode), .cmd_key_o(key), .cmd_value_o(value),
      .res_valid_i(res_valid), .res_ready_o(res_ready),
      .busy_o(busy), .done_o(done), .cmds_sent_o(cmds_sent),
      .results_o(results), .outstanding_o(outstanding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   function automatic cmd_t ref_cmd(input logic [31:0] l, input vec_t v);
      cmd_t c;
      c.key = {v.base | (l[7:0] & v.bm), l[31:8] & v.km};
      c.val = l[15:0];
      if (v.mode == 2'd1) c.op = OP_INSERT;
      else if (l[31:30] == 2'b00) c.op = OP_SEARCH;
      else if (l[31:30] == 2'b01) c.op = OP_INSERT;
      else if (l[31:30] == 2'b10) c.op = OP_DELETE;
      else c.op = (v.mode == 2'd2 && v.mix) ? OP_INIT : OP_SEARCH;
      return c;
   endfunction

   task automatic build_q(input vec_t v);
      logic [31:0] l;
      cmd_t c;
      expq.delete();
      if (v.init_first || v.mode == 2'd0) begin
         c.op = OP_INIT; c.key = 0; c.val = 0;
         expq.push_back(c);
      end
      if (v.mode != 2'd0) begin
         l = (v.seed == 0) ? 32'h1 : v.seed;
         for (int i = 0; i < v.cnt; i++) begin
            expq.push_back(ref_cmd(l, v));
            l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
         end
      end
   endtask

   task automatic step();
      logic hs, racc;
      cmd_t c;
      #1;
      hs   = cmd_valid & cmd_ready;
      racc = res_valid && (out_m != 0);
      if (out_m == MAXO && !res_valid) chk("cap_gate", cmd_valid, 0);
      if (cmd_valid && held) chk("stable", {opcode, key, value}, {hv.op, hv.key, hv.val});
      if (hs) begin
         held = 0;
         if (expq.size() == 0) begin
            chk("extra_cmd", 1, 0);
         end else begin
            c = expq.pop_front();
            chk("cmd", {opcode, key, value}, {c.op, c.key, c.val});
         end
      end else if (cmd_valid) begin
         held = 1;
         hv.op = opcode; hv.key = key; hv.val = value;
      end
      if (hs && !racc) out_m++;
      else if (!hs && racc) out_m--;
      if (hs && sent_m != 16'hFFFF) sent_m++;
      if (racc && res_m != 16'hFFFF) res_m++;
      @(posedge clk); #1;
      chk("outstanding", outstanding, out_m);
      chk("cmds_sent", cmds_sent, sent_m);
      chk("results", results, res_m);
   endtask

   task automatic chk_reset();
      chk("rst_valid", cmd_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sent", cmds_sent, 0);
      chk("rst_results", results, 0);
      chk("rst_outst", outstanding, 0);
      chk("rst_op", opcode, OP_INIT);
      chk("rst_key", key, 0);
      chk("rst_value", value, 0);
      chk("rst_res_ready", res_ready, 1);
   endtask

   task automatic do_reset();
      rst = 1; start = 0; abort = 0; res_valid = 0; cmd_ready = 0;
      @(posedge clk); #1;
      chk("res_ready_in_rst", res_ready, 1);
      chk_reset();
      rst = 0;
      out_m = 0; sent_m = 0; res_m = 0; held = 0;
      expq.delete();
   endtask

   task automatic launch(input vec_t v);
      build_q(v);
      mode = v.mode; init_first = v.init_first; mix = v.mix;
      cmd_cnt = 16'(v.cnt); seed = v.seed; base = v.base; bm = v.bm; km = v.km;
      sent_m = 0; res_m = 0; held = 0;
      res_valid = 0; abort = 0; start = 1;
      step();
      start = 0;
      chk("valid_rise", cmd_valid, v.exp_sent != 0);
      chk("busy_run", busy, 1);
   endtask

   task automatic drain_wait(input string nm);
      int n = 0;
      res_valid = 1;
      while (!done && n < 200) begin
         step();
         n++;
      end
      chk({nm, "_done"}, done, 1);
      res_valid = 0;
      step();
      chk({nm, "_done_pulse"}, done, 0);
      expq.delete();
   endtask

   task automatic run_cfg(input vec_t v, input string nm);
      int n = 0;
      launch(v);
      while (!done && n < 4000) begin
         cmd_ready = ($urandom_range(99) < v.rdy_pct);
         if (out_m != 0) res_valid = ($urandom_range(99) < v.res_pct);
         else res_valid = ($urandom_range(9) == 0);
         start = ($urandom_range(19) == 0);
         step();
         n++;
      end
      start = 0;
      if (!done) begin
         chk({nm, "_timeout"}, 0, 1);
         do_reset();
      end else begin
         chk({nm, "_sent"}, cmds_sent, v.exp_sent);
         chk({nm, "_results"}, results, v.exp_sent);
         chk({nm, "_left"}, expq.size(), 0);
         res_valid = 0;
         step();
         chk({nm, "_done_pulse"}, done, 0);
         chk({nm, "_idle"}, busy, 0);
         step();
         step();
         chk({nm, "_hold"}, cmds_sent, v.exp_sent);
      end
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v;
      rst = 1; start = 0; abort = 0; mode = 0; init_first = 0; mix = 0;
      cmd_cnt = 0; seed = 0; base = 0; bm = 0; km = 0;
      cmd_ready = 0; res_valid = 0;
      out_m = 0; sent_m = 0; res_m = 0; held = 0;
      @(posedge clk); @(posedge clk); #1;
      chk_reset();
      rst = 0;

      tbl.push_back('{2'd0, 1'b1, 1'b0, 5,  32'h1234_5678, 8'h00, 8'hFF, 24'hFFFFFF, 100, 40, 1});
      tbl.push_back('{2'd1, 1'b0, 1'b0, 20, 32'hACE1_0001, 8'h05, 8'h00, 24'h000007, 100, 50, 20});
      tbl.push_back('{2'd2, 1'b1, 1'b0, 30, 32'hDEAD_BEEF, 8'h10, 8'h0F, 24'h00FFFF, 50, 50, 31});
      tbl.push_back('{2'd3, 1'b0, 1'b1, 25, 32'h0BAD_F00D, 8'h80, 8'h7F, 24'hFFFFFF, 60, 30, 25});
      tbl.push_back('{2'd1, 1'b0, 1'b0, 0,  32'h1111_1111, 8'h00, 8'h00, 24'h000000, 100, 50, 0});
      tbl.push_back('{2'd2, 1'b1, 1'b0, 0,  32'h2222_2222, 8'h00, 8'hFF, 24'hFFFFFF, 100, 50, 1});
      tbl.push_back('{2'd2, 1'b0, 1'b1, 40, 32'h0000_0000, 8'h00, 8'hFF, 24'hFFFFFF, 40, 60, 40});
      tbl.push_back('{2'd0, 1'b0, 1'b0, 7,  32'h5555_AAAA, 8'h00, 8'hFF, 24'hFFFFFF, 70, 50, 1});
      tbl.push_back('{2'd2, 1'b0, 1'b1, 30, 32'hC0FF_EE01, 8'h3C, 8'hC3, 24'h0F0F0F, 30, 70, 30});
      tbl.push_back('{2'd2, 1'b0, 1'b1, 30, 32'hC0FF_EE01, 8'h3C, 8'hC3, 24'h0F0F0F, 30, 70, 30});
      foreach (tbl[i]) run_cfg(tbl[i], $sformatf("vec%0d", i));

      for (int r = 0; r < 6; r++) begin
         v.mode = 2'($urandom_range(3));
         v.init_first = 1'($urandom_range(1));
         v.mix = 1'($urandom_range(1));
         v.cnt = $urandom_range(40);
         v.seed = ($urandom_range(4) == 0) ? 32'h0 : $urandom;
         v.base = 8'($urandom); v.bm = 8'($urandom); v.km = 24'($urandom);
         v.rdy_pct = $urandom_range(100, 30);
         v.res_pct = $urandom_range(90, 20);
         v.exp_sent = ((v.init_first || v.mode == 0) ? 1 : 0) + ((v.mode == 0) ? 0 : v.cnt);
         run_cfg(v, $sformatf("rnd%0d", r));
      end

      // no results returned: issue stops at the cap, resumes as results arrive
      v = '{2'd2, 1'b0, 1'b0, 1000, 32'h600D_CAFE, 8'h00, 8'hFF, 24'hFFFFFF, 100, 0, 1000};
      cmd_ready = 1;
      launch(v);
      repeat (30) step();
      chk("cap_sent", cmds_sent, MAXO);
      chk("cap_valid_low", cmd_valid, 0);
      chk("cap_outst", outstanding, MAXO);
      res_valid = 1;
      repeat (MAXO) step();
      chk("cap_resume", cmds_sent, 2 * MAXO);
      res_valid = 0; abort = 1;
      step();
      abort = 0;
      drain_wait("cap_abort");
      chk("cap_abort_sent", cmds_sent, 2 * MAXO);

      // abort while command 5 is stalled
      v = '{2'd1, 1'b0, 1'b0, 20, 32'h0000_0ABC, 8'h05, 8'h00, 24'h000007, 100, 0, 20};
      cmd_ready = 1;
      launch(v);
      for (int n = 0; n < 20 && sent_m < 4; n++) step();
      chk("ab_sent4", cmds_sent, 4);
      cmd_ready = 0; abort = 1;
      step();
      abort = 0;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("ab_held_valid", cmd_valid, 1);
      end
      cmd_ready = 1;
      step();
      chk("ab_no_cmd6", cmd_valid, 0);
      step(); step();
      chk("ab_sent5", cmds_sent, 5);
      chk("ab_busy", busy, 1);
      drain_wait("ab");
      chk("ab_results", results, 5);

      // reset in the middle of a run
      v = '{2'd1, 1'b0, 1'b0, 50, 32'h7777_0001, 8'h00, 8'hFF, 24'hFFFFFF, 100, 50, 50};
      cmd_ready = 1;
      launch(v);
      res_valid = 1;
      repeat (6) step();
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ht_cmd_traffic_gen.md
HT_CMD_TRAFFIC_GEN -- requirements
Module: ht_cmd_traffic_gen

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32, command key width.
REQ-002 SHALL have parameter VALUE_WIDTH, default 16, command value width.
REQ-003 SHALL have parameter BUCKET_WIDTH, default 8, key MSBs that select the bucket (dummy hash).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, command/result counter width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8, cap on commands without results.
REQ-006 SHALL have ports, one per line:
 clk_i  in  1  clock
 rst_i  in  1  reset; one clock; synchronous, active-high
 start_i  in  1  start pulse, honoured in IDLE only
 abort_i  in  1  stop issuing new commands
 mode_i  in  2  0 INIT_ONLY, 1 INSERT_BURST, 2 MIXED, 3 BUCKET_STRESS
 init_first_i  in  1  issue OP_INIT before the run
 mixed_init_en_i  in  1  allow OP_INIT inside MIXED
 cmd_cnt_i  in  CNT_WIDTH  commands in the run phase
 seed_i  in  32  LFSR seed
 bucket_base_i  in  BUCKET_WIDTH  bucket OR-base
 bucket_mask_i  in  BUCKET_WIDTH  random bucket bits
 key_low_mask_i  in  KEY_WIDTH-BUCKET_WIDTH  random low key bits
 cmd_valid_o  out  1  command valid
 cmd_ready_i  in  1  command ready
 cmd_opcode_o  out  ht_opcode_t  OP_INIT/OP_SEARCH/OP_INSERT/OP_DELETE, hash_table package encoding
 cmd_key_o  out  KEY_WIDTH  key
 cmd_value_o  out  VALUE_WIDTH  value
 res_valid_i  in  1  DUT result valid
 res_ready_o  out  1  constant 1
 busy_o  out  1  not IDLE
 done_o  out  1  one-cycle end pulse
 cmds_sent_o  out  CNT_WIDTH  accepted commands this run
 results_o  out  CNT_WIDTH  received results this run
 outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count

Function
REQ-007 SHALL be an FSM with states IDLE, INIT, RUN, DRAIN, DONE.
REQ-008 IDLE+start_i SHALL latch mode, masks, base, cmd_cnt and seed (seed 0 replaced by 32'h1), clear both counters, and enter INIT if init_first_i or mode 0, else RUN; cmd_valid_o SHALL rise the following cycle.
REQ-009 INIT SHALL present OP_INIT, key 0, value 0; on handshake it SHALL go to RUN, or to DRAIN if mode 0 or cmd_cnt==0.
REQ-010 RUN SHALL issue cmd_cnt commands, then enter DRAIN on the handshake of the last one; cmd_cnt==0 SHALL go straight to DRAIN.
REQ-011 Handshake = cmd_valid_o & cmd_ready_i; while valid, opcode/key/value SHALL stay stable until handshake.
REQ-012 The 32-bit Galois LFSR (taps 32,22,2,1) SHALL advance only on a RUN handshake.
REQ-013 Key = {bucket_base | (lfsr[BUCKET_WIDTH-1:0] & bucket_mask), lfsr[31:8] zero-extended/truncated & key_low_mask}; value = lfsr[VALUE_WIDTH-1:0] rotated by 16.
REQ-014 Mode 1 SHALL issue OP_INSERT only; modes 2/3 SHALL map lfsr[31:30]: 00 SEARCH, 01 INSERT, 10 DELETE, 11 INIT if mixed_init_en_i (mode 2 only), else SEARCH.
REQ-015 cmd_valid_o SHALL be low when outstanding==MAX_OUTSTANDING and no result arrives this cycle.
REQ-016 Outstanding SHALL +1 on handshake, -1 on res_valid_i, stay unchanged on both; res_valid_i at 0 SHALL be ignored, with no wrap.
REQ-017 Counters SHALL saturate at all-ones.
REQ-018 abort_i in INIT/RUN SHALL go to DRAIN at once if cmd_valid_o is low or a handshake occurs that cycle, else after the pending handshake; abort_i in IDLE/DRAIN/DONE SHALL be ignored.
REQ-019 DRAIN SHALL go to DONE when outstanding==0; DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-020 start_i outside IDLE SHALL be ignored; counters SHALL keep their values in IDLE.

Reset
REQ-021 rst_i high at a clk_i edge SHALL force IDLE, cmd_valid_o=0, done_o=0, busy_o=0, counters=0, outstanding=0, LFSR=32'h1, opcode=OP_INIT, key=0, value=0, in any state including mid-handshake.
REQ-022 res_ready_o SHALL be 1 during and after reset.

Verification
REQ-023 mode 0, init_first 1, ready=1, one result after 3 cycles -> one OP_INIT key 0; done_o pulses; cmds_sent=1, results=1.
REQ-024 mode 1, cmd_cnt=20, base=8'h05, bucket_mask=0, key_low_mask=7 -> 20 OP_INSERTs, all keys 32'h05_00_00_0x with x≤7, done after 20 results.
REQ-025 mode 2, cmd_cnt=1000, results never returned -> exactly MAX_OUTSTANDING=8 handshakes, then valid stays low; returning 8 results -> issue resumes.
REQ-026 cmd_ready_i toggled randomly -> opcode/key/value never change while valid and not ready; same seed_i gives an identical sequence on a second run.
REQ-027 abort_i on RUN command 5 with ready=0 -> command 5 held until accepted, no command 6, DRAIN then done_o; rst_i mid-RUN -> all outputs at reset values next cycle.
